// File: rtl/adder_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_arb_pkg
// Shared constants and types for the shared-adder arbiter:
//   NREQ         default number of requesters
//   ID_W         width of a requester index (fixed at 2 bits)
//   CNT_W        width of the accepted-operation counter
//   slot_state_t state of the single result slot (EMPTY=0, FULL=1)
// -----------------------------------------------------------------------------
package adder_arb_pkg;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/prefix_adder.sv
// -----------------------------------------------------------------------------
// prefix_adder
// Purely combinational N-bit Kogge-Stone adder. It has no carry-in, and the
// carry-out is not produced, so X = (A + B) mod 2^N.
// Ports:
//   A  in  [N-1:0]  first operand
//   B  in  [N-1:0]  second operand
//   X  out [N-1:0]  sum, truncated to N bits
// -----------------------------------------------------------------------------
module prefix_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] X
);

  // Kogge-Stone prefix network. At each level, bit i combines its
  // (generate, propagate) pair with the pair at distance d below it. d doubles
  // at each level, so after log2(N) levels g[i] is the carry out of bit i.
  function automatic logic [N-1:0] ks_sum(input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] g_nxt;
    logic [N-1:0] p_nxt;
    logic [N-1:0] carry;
    g = a & b;
    p = a ^ b;
    for (int d = 1; d < N; d = d * 2) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = d; i < N; i++) begin
        g_nxt[i] = g[i] | (p[i] & g[i-d]);
        p_nxt[i] = p[i] & p[i-d];
      end
      g = g_nxt;
      p = p_nxt;
    end
    // The carry into bit i is the group generate of bits [i-1:0].
    carry = '0;
    for (int i = 1; i < N; i++) begin
      carry[i] = g[i-1];
    end
    return (a ^ b) ^ carry;
  endfunction

  assign X = ks_sum(A, B);

endmodule

// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
// Several requesters share one combinational adder. A round-robin arbiter
// grants one requester per cycle whenever the single result slot can accept a
// new value. The sum of the granted operands is registered into the slot
// together with the requester index.
// Ports:
//   clk        in                 single clock, rising edge
//   rst        in                 synchronous active-high reset
//   req_valid  in  [NREQ-1:0]     per-requester operand valid
//   req_ready  out [NREQ-1:0]     per-requester accept strobe (one-hot or zero)
//   A          in  [NREQ*N-1:0]   packed first operands, requester i at [i*N +: N]
//   B          in  [NREQ*N-1:0]   packed second operands, same packing as A
//   X          out [N-1:0]        registered sum
//   res_valid  out                X / res_id hold a valid result
//   res_id     out [1:0]          index of the requester that owns X
//   res_ready  in                 downstream takes the result this cycle
//   op_count   out [15:0]         accepted operations, wraps at 2^16
// -----------------------------------------------------------------------------
module adder_share_arbiter
  import adder_arb_pkg::ID_W, adder_arb_pkg::CNT_W, adder_arb_pkg::slot_state_t,
         adder_arb_pkg::EMPTY, adder_arb_pkg::FULL;
#(
  parameter int N    = 4,
  parameter int NREQ = adder_arb_pkg::NREQ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] A,
  input  logic [NREQ*N-1:0] B,
  output logic [N-1:0]      X,
  output logic              res_valid,
  output logic [ID_W-1:0]   res_id,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  op_count
);

  slot_state_t     state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] next_ptr;
  logic            found;
  logic            slot_free;
  logic            transfer;
  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;
  logic [N-1:0]    sum;

  // The slot can take a new result when it is empty, or when it is full and
  // the current result leaves this cycle. Nothing is granted while rst is high.
  assign slot_free = ~rst & ((state == EMPTY) | res_ready);

  // Round-robin search: scan from ptr upward and wrap. The scan runs from the
  // farthest offset down to offset 0, so the last match, which is the one
  // kept, is the requester nearest to ptr.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default value first.
    // Otherwise some path leaves it unassigned, and synthesis infers a latch.
    found     = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        found     = 1'b1;
        grant_idx = ID_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign transfer = found & slot_free;

  always_comb begin
    req_ready = '0;
    if (transfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // The pointer moves to the requester just after the one that was granted.
  // This way the requester that was just served has the lowest priority in
  // the next cycle.
  assign next_ptr = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;

  // Operand mux in front of the shared adder.
  assign a_sel = A[int'(grant_idx) * N +: N];
  assign b_sel = B[int'(grant_idx) * N +: N];

  prefix_adder #(
    .N (N)
  ) u_adder (
    .A (a_sel),
    .B (b_sel),
    .X (sum)
  );

  // Slot FSM, result registers, round-robin pointer and operation counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples values from before the edge, whatever the statement order.
    if (rst) begin
      state    <= EMPTY;
      X        <= '0;
      res_id   <= '0;
      ptr      <= '0;
      op_count <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (transfer) begin
            state  <= FULL;
            X      <= sum;
            res_id <= grant_idx;
          end
        end
        FULL: begin
          // With res_ready low, X and res_id stay frozen. transfer cannot be
          // high in that case, because slot_free is low.
          if (res_ready) begin
            if (transfer) begin
              X      <= sum;
              res_id <= grant_idx;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase

      if (transfer) begin
        ptr      <= next_ptr;
        op_count <= op_count + 1'b1;
      end
    end
  end

  // FULL is encoded as 1, so res_valid comes straight from the state flop.
  assign res_valid = (state == FULL);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
// Directed bench for adder_share_arbiter with N=4 and NREQ=4. A table of
// per-cycle records gives the inputs for one cycle, the req_ready expected
// before the edge, and the slot contents expected after the edge. Separate
// sequences cover the full adder truth table and the 16-bit counter wrap.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] A;
  logic [NREQ*N-1:0] B;
  logic [N-1:0]      X;
  logic              res_valid;
  logic [1:0]        res_id;
  logic              res_ready;
  logic [15:0]       op_count;

  int total = 0;
  int bad   = 0;

  adder_share_arbiter #(
    .N    (N),
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .A         (A),
    .B         (B),
    .X         (X),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_ready (res_ready),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        rr;
    logic [3:0]  exp_ready;   // req_ready before the edge
    logic        exp_rv;      // res_valid after the edge
    logic [3:0]  exp_x;       // X after the edge, checked only when exp_rv=1
    logic [1:0]  exp_id;      // res_id after the edge, checked only when exp_rv=1
    logic [15:0] exp_cnt;     // op_count after the edge
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one record. Check req_ready mid-cycle, take the edge, then check
  // the registered outputs 1 ns after the edge.
  task automatic apply_vec(input int idx, input vec_t v);
    rst       = v.rst;
    req_valid = v.valid;
    A         = v.a;
    B         = v.b;
    res_ready = v.rr;
    #2;
    check($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    check($sformatf("v%0d res_valid", idx), 32'(res_valid), 32'(v.exp_rv));
    check($sformatf("v%0d op_count", idx), 32'(op_count), 32'(v.exp_cnt));
    if (v.exp_rv) begin
      check($sformatf("v%0d X", idx), 32'(X), 32'(v.exp_x));
      check($sformatf("v%0d res_id", idx), 32'(res_id), 32'(v.exp_id));
    end
  endtask

  initial begin
    // Default operands: A0..A3 = 1,3,5,7 and B0..B3 = 4,3,2,1,
    // so the sums for requesters 0..3 are 5,6,7,8.
    //           rst   valid  a         b          rr    ready  rv    x     id     cnt
    // Reset held for 2 cycles with every requester valid.
    vecs[0]  = '{1'b1, 4'hF, 16'h7531, 16'h1234, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 16'd0};
    vecs[1]  = '{1'b1, 4'hF, 16'h7531, 16'h1234, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 16'd0};
    vecs[2]  = '{1'b0, 4'h0, 16'h7531, 16'h1234, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 16'd0};
    // Single request from requester 2: 9 + 8 = 0x11, truncated to 0x1.
    vecs[3]  = '{1'b0, 4'h4, 16'h0900, 16'h0800, 1'b1, 4'h4, 1'b1, 4'h1, 2'd2, 16'd1};
    // Drain the result, then res_ready while EMPTY has no effect.
    vecs[4]  = '{1'b0, 4'h0, 16'h7531, 16'h1234, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 16'd1};
    vecs[5]  = '{1'b0, 4'h0, 16'h7531, 16'h1234, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 16'd1};
    // Reset so that ptr=0, then 8 cycles of fairness with all requesters valid.
    vecs[6]  = '{1'b1, 4'hF, 16'h7531, 16'h1234, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 16'd0};
    vecs[7]  = '{1'b0, 4'hF, 16'h7531, 16'h1234, 1'b1, 4'h1, 1'b1, 4'h5, 2'd0, 16'd1};
    vecs[8]  = '{1'b0, 4'hF, 16'h7531, 16'h1234, 1'b1, 4'h2, 1'b1, 4'h6, 2'd1, 16'd2};
    vecs[9]  = '{1'b0, 4'hF, 16'h7531, 16'h1234, 1'b1, 4'h4, 1'b1, 4'h7, 2'd2, 16'd3};
    vecs[10] = '{1'b0, 4'hF, 16'h7531, 16'h1234, 1'b1, 4'h8, 1'b1, 4'h8, 2'd3, 16'd4};
    vecs[11] = '{1'b0, 4'hF, 16'h7531, 16'h1234, 1'b1, 4'h1, 1'b1, 4'h5, 2'd0, 16'd5};
    vecs[12] = '{1'b0, 4'hF, 16'h7531, 16'h1234, 1'b1, 4'h2, 1'b1, 4'h6, 2'd1, 16'd6};
    vecs[13] = '{1'b0, 4'hF, 16'h7531, 16'h1234, 1'b1, 4'h4, 1'b1, 4'h7, 2'd2, 16'd7};
    vecs[14] = '{1'b0, 4'hF, 16'h7531, 16'h1234, 1'b1, 4'h8, 1'b1, 4'h8, 2'd3, 16'd8};
    // Backpressure for 3 cycles with requesters 1 and 3 pending (ptr=0).
    vecs[15] = '{1'b0, 4'hA, 16'h7531, 16'h1234, 1'b0, 4'h0, 1'b1, 4'h8, 2'd3, 16'd8};
    vecs[16] = '{1'b0, 4'hA, 16'h7531, 16'h1234, 1'b0, 4'h0, 1'b1, 4'h8, 2'd3, 16'd8};
    vecs[17] = '{1'b0, 4'hA, 16'h7531, 16'h1234, 1'b0, 4'h0, 1'b1, 4'h8, 2'd3, 16'd8};
    // Release: requester 1 is granted in the same cycle, then requester 3.
    vecs[18] = '{1'b0, 4'hA, 16'h7531, 16'h1234, 1'b1, 4'h2, 1'b1, 4'h6, 2'd1, 16'd9};
    vecs[19] = '{1'b0, 4'hA, 16'h7531, 16'h1234, 1'b1, 4'h8, 1'b1, 4'h8, 2'd3, 16'd10};
    // Grant requester 2 (ptr becomes 3), hold FULL, then reset mid-operation.
    vecs[20] = '{1'b0, 4'h4, 16'h7531, 16'h1234, 1'b1, 4'h4, 1'b1, 4'h7, 2'd2, 16'd11};
    vecs[21] = '{1'b0, 4'h0, 16'h7531, 16'h1234, 1'b0, 4'h0, 1'b1, 4'h7, 2'd2, 16'd11};
    vecs[22] = '{1'b1, 4'hF, 16'h7531, 16'h1234, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 16'd0};
    // After reset, ptr is 0, so requester 0 wins and not requester 3.
    vecs[23] = '{1'b0, 4'hF, 16'h7531, 16'h1234, 1'b0, 4'h1, 1'b1, 4'h5, 2'd0, 16'd1};
    // Requester 1 pends under backpressure, then drops; requester 2 is served.
    vecs[24] = '{1'b0, 4'h2, 16'h7531, 16'h1234, 1'b0, 4'h0, 1'b1, 4'h5, 2'd0, 16'd1};
    vecs[25] = '{1'b0, 4'h4, 16'h7531, 16'h1234, 1'b1, 4'h4, 1'b1, 4'h7, 2'd2, 16'd2};

    rst       = 1'b1;
    req_valid = '0;
    A         = '0;
    B         = '0;
    res_ready = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply_vec(i, vecs[i]);
    end

    // Full adder truth table through requester 0, one result per cycle.
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'h1;
    res_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = {12'h000, 4'(a)};
        B = {12'h000, 4'(b)};
        @(posedge clk);
        #1;
        check($sformatf("sum %0h+%0h", a, b), 32'(X), 32'((a + b) % 16));
      end
    end

    // Counter wrap: 65535 back-to-back transfers, then one more.
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'hF;
    res_ready = 1'b1;
    A         = 16'hFFFF;
    B         = 16'hFFFF;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
    end
    #1;
    check("preload op_count", 32'(op_count), 32'd65535);
    @(posedge clk);
    #1;
    check("wrap op_count", 32'(op_count), 32'd0);
    check("wrap X F+F", 32'(X), 32'hE);
    check("wrap res_valid", 32'(res_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 Parameter N, default 4: operand and result width in bits.
REQ-002 Parameter NREQ, default 4: number of requesters; ID width is 2 bits.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  NREQ  per-requester operand-valid bit.
REQ-006 req_ready  output  NREQ  per-requester accept strobe, one-hot or zero.
REQ-007 A  input  NREQ*N  packed first operands; requester i uses bits [i*N +: N].
REQ-008 B  input  NREQ*N  packed second operands, packed the same way as A.
REQ-009 X  output  N  registered sum.
REQ-010 res_valid  output  1  X and res_id hold a valid result.
REQ-011 res_id  output  2  index of the requester that owns X.
REQ-012 res_ready  input  1  downstream accepts the result this cycle.
REQ-013 op_count  output  16  count of accepted operations.

Function
REQ-014 The block shall share one combinational N-bit adder among all requesters.
REQ-015 X shall equal (A_g + B_g) mod 2^N; no carry-out is produced.
REQ-016 The result slot shall use a two-state FSM: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-017 The slot is free when the FSM is EMPTY, or when it is FULL and res_ready=1.
REQ-018 When the slot is free, the arbiter shall grant the first asserted req_valid found round-robin from pointer ptr upward, wrapping NREQ-1 to 0.
REQ-019 req_ready shall be a combinational one-hot at the granted index.
REQ-020 req_ready shall be all-zero when the slot is not free or no req_valid is set.
REQ-021 A transfer occurs on req_valid[g] & req_ready[g].
REQ-022 On a transfer, ptr shall become (g+1) mod NREQ; otherwise ptr shall hold.
REQ-023 The cycle after a transfer: res_valid=1, X=sum, res_id=g (latency 1 cycle).
REQ-024 FSM transitions:
- EMPTY -> FULL on a transfer.
- FULL -> EMPTY on res_ready=1 with no transfer.
- FULL -> FULL on res_ready=1 with a transfer (back-to-back, 1 op/cycle), with X and res_id reloaded.
- FULL holds on res_ready=0.
REQ-025 While FULL and res_ready=0, X and res_id shall stay stable.
REQ-026 A requester whose req_valid drops before grant shall lose nothing; no state is kept per request.
REQ-027 op_count shall increment by 1 per transfer and wrap from 65535 to 0.
REQ-028 res_ready asserted while EMPTY shall have no effect.

Reset
REQ-029 While rst=1 at a clock edge, the block shall load: FSM=EMPTY, res_valid=0, X=0, res_id=0, ptr=0, op_count=0.
REQ-030 During any cycle with rst=1, req_ready shall be all-zero.
REQ-031 Reset asserted mid-operation shall discard a pending FULL result without handshaking it.

Structure
REQ-032 A shared package adder_arb_pkg shall hold NREQ, the ID width (2), the op_count width (16) and the FSM state encoding (EMPTY=0, FULL=1).
REQ-033 The adder shall be a separate sub-module prefix_adder: N-bit Kogge-Stone, combinational, ports X, A, B.
REQ-034 The operand mux, arbiter and FSM shall stay in the top module.

Verification
REQ-035 Reset check: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0 throughout; after release X=0, res_valid=0, op_count=0.
REQ-036 Single request: requester 2 sends A=4'h9, B=4'h8, res_ready=1 -> next cycle X=4'h1, res_id=2, res_valid=1, op_count=1.
REQ-037 Fairness: all four req_valid held high with res_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3 at one result per cycle; op_count=8.
REQ-038 Backpressure: res_ready=0 for 3 cycles while FULL, with requesters 1 and 3 pending -> req_ready=0 and X/res_id frozen; on release, requester 1 is granted in that same cycle.
REQ-039 Wrap: preload 65535 operations, then do one more -> op_count=0; also A=4'hF, B=4'hF -> X=4'hE.
REQ-040 Mid-operation reset: FULL with res_ready=0, then rst=1 for 1 cycle -> res_valid=0, ptr=0, and the next grant with all req_valid set goes to requester 0.
